mips_muldiv: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the 32-bit MIPS datapath. It sits directly downstream of the register file and takes rs/rt from the register file's two read ports as `operand_a`/`operand_b`. It executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle. HI/LO are continuously readable so that MFHI/MFLO can route them to the register file's write-data path.

---
 rtl/mips_muldiv_pkg.sv | 20 ++
 rtl/mips_muldiv_iter.sv | 59 +++++
 rtl/mips_muldiv.sv | 115 +++++++++++
 tb/tb_mips_muldiv.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared opcode encodings, FSM states and iteration count for the MIPS multiply/divide unit.
package mips_muldiv_pkg;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam int ITER_CNT = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/mips_muldiv_iter.sv
// Unsigned iterative datapath: one shift-add (multiply) or restoring-subtract (divide) step per cycle.
module muldiv_iter
   import mips_muldiv_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  step,
   input  logic                  is_div,
   input  logic [DATA_W-1:0]     mag_a,
   input  logic [DATA_W-1:0]     mag_b,
   output logic [2*DATA_W-1:0]   acc,
   output logic [DATA_W-1:0]     rem_out,
   output logic                  last
);

   localparam int CW = $clog2(ITER_CNT);

   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] opnd;
   logic [DATA_W:0]   rem;
   logic              div_mode;
   logic [DATA_W:0]   add_sum;
   logic [DATA_W+1:0] trial;

   // acc holds {partial product, remaining multiplier bits} for multiply and the dividend/quotient in its low half for divide
   always_comb begin
      add_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
      trial   = {rem, acc[DATA_W-1]} - {2'b00, opnd};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    cnt <= '0;
      else if (load) cnt <= '0;
      else if (step) cnt <= cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (load) begin
         opnd     <= is_div ? mag_b : mag_a;
         acc      <= {{DATA_W{1'b0}}, (is_div ? mag_a : mag_b)};
         rem      <= '0;
         div_mode <= is_div;
      end else if (step) begin
         if (div_mode) begin
            acc <= {acc[2*DATA_W-1:DATA_W], acc[DATA_W-2:0], ~trial[DATA_W+1]};
            rem <= trial[DATA_W+1] ? {rem[DATA_W-1:0], acc[DATA_W-1]} : trial[DATA_W:0];
         end else begin
            acc <= {add_sum, acc[DATA_W-1:1]};
         end
      end
   end

   assign rem_out = rem[DATA_W-1:0];
   assign last    = (cnt == CW'(ITER_CNT - 1));

endmodule

// File: rtl/mips_muldiv.sv
// MIPS multiply/divide unit: control FSM, sign handling and the architectural HI/LO registers.
module mips_muldiv
   import mips_muldiv_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] operand_a,
   input  logic [DATA_W-1:0] operand_b,
   output logic              busy,
   output logic              done,
   output logic              div_by_zero,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   state_t state, state_nxt;

   logic                load, step, last;
   logic                is_muldiv, is_div_op, div_zero, signed_op, sign_a, sign_b;
   logic                neg_res, neg_rem, div_q, dz_q;
   logic [DATA_W-1:0]   mag_a, mag_b, quo_fix, rem_fix, rem;
   logic [2*DATA_W-1:0] acc, prod_fix;

   assign is_muldiv = ~op[2];
   assign is_div_op = ~op[2] & op[1];
   assign signed_op = ~op[0];
   assign sign_a    = signed_op & operand_a[DATA_W-1];
   assign sign_b    = signed_op & operand_b[DATA_W-1];
   assign mag_a     = sign_a ? -operand_a : operand_a;
   assign mag_b     = sign_b ? -operand_b : operand_b;
   assign div_zero  = is_div_op & (operand_b == '0);

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: begin
            if (start && is_muldiv) begin
               if (div_zero) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = CALC;
                  load      = 1'b1;
               end
            end
         end
         CALC: begin
            step = 1'b1;
            if (last) state_nxt = FIX;
         end
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   muldiv_iter #(.DATA_W(DATA_W)) u_iter (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .step    (step),
      .is_div  (is_div_op),
      .mag_a   (mag_a),
      .mag_b   (mag_b),
      .acc     (acc),
      .rem_out (rem),
      .last    (last)
   );

   // Signs are captured at acceptance because the operand buses change while the unit iterates
   always_ff @(posedge clk) begin
      if (load) begin
         neg_res <= sign_a ^ sign_b;
         neg_rem <= sign_a;
         div_q   <= is_div_op;
      end
   end

   assign prod_fix = neg_res ? -acc : acc;
   assign quo_fix  = neg_res ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
   assign rem_fix  = neg_rem ? -rem : rem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         hi    <= '0;
         lo    <= '0;
         dz_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         dz_q  <= (state == IDLE) && start && div_zero;
         if (state == IDLE && start && op == OP_MTHI) hi <= operand_a;
         if (state == IDLE && start && op == OP_MTLO) lo <= operand_a;
         if (state == FIX) begin
            if (div_q) begin
               hi <= rem_fix;
               lo <= quo_fix;
            end else begin
               hi <= prod_fix[2*DATA_W-1:DATA_W];
               lo <= prod_fix[DATA_W-1:0];
            end
         end
      end
   end

   assign busy        = (state == CALC) || (state == FIX);
   assign done        = (state == DONE);
   assign div_by_zero = dz_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv: expected HI/LO pushed at issue, compared when done pulses.
module tb_mips_muldiv;
   import mips_muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'b111;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;

   mips_muldiv #(.DATA_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("hi", hi, mon_e.hi);
            chk("lo", lo, mon_e.lo);
            chk("div_by_zero", div_by_zero, mon_e.dz);
         end
      end
   end

   task automatic mt(input logic [2:0] o, input logic [31:0] v);
      @(negedge clk);
      start = 1'b1; op = o; operand_a = v; operand_b = '0;
      @(posedge clk); #1;
      start = 1'b0; op = 3'b111;
      if (o == OP_MTHI) chk("mthi", hi, v);
      else              chk("mtlo", lo, v);
      chk("mt_no_done", done, 1'b0);
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz,
                         input int lat, input bit inject);
      int k;
      bit seen;
      @(negedge clk);
      start = 1'b1; op = o; operand_a = a; operand_b = b;
      sb_q.push_back('{eh, el, edz});
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_accept", busy, (lat != 0));
      k = 0;
      seen = 1'b0;
      while (!seen && k < 100) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (inject && k == 5) begin
               start = 1'b1; op = OP_MTHI; operand_a = 32'h1234_5678;
            end
            if (k == 6) start = 1'b0;
            @(posedge clk); #1;
            k++;
         end
      end
      chk("done_latency", seen ? 64'(k) : 64'd999, 64'(lat));
      @(posedge clk); #1;
      chk("done_pulse", done, 1'b0);
      chk("busy_idle", busy, 1'b0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      mt(OP_MTHI, 32'hAAAA_5555);
      mt(OP_MTLO, 32'h5555_AAAA);

      // MULT abandoned by reset partway through the iterations
      @(negedge clk);
      start = 1'b1; op = OP_MULT; operand_a = 32'd9; operand_b = 32'd9;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (11) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_hi", hi, 32'h0);
      chk("midrst_lo", lo, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(OP_MULTU, 32'd5, 32'd7, 32'h0, 32'd35, 1'b0, 33, 1'b0);
      run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 1'b0);
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 1'b1);
      run_op(OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0, 32'd30, 1'b0, 33, 1'b0);
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 1'b0);
      run_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 1'b1);
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33, 1'b0);
      run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33, 1'b0);

      mt(OP_MTHI, 32'h11);
      mt(OP_MTLO, 32'h22);
      run_op(OP_DIVU, 32'd9, 32'd0, 32'h11, 32'h22, 1'b1, 0, 1'b0);

      mt(OP_MTHI, 32'hDEAD_BEEF);
      chk("mthi_lo_kept", lo, 32'h22);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
